// File: rtl/dot_product_stream_pkg.sv
// dot_product_stream_pkg: shared constants and elaboration helpers for the dot-product datapath
package dot_product_stream_pkg;
  localparam int SGN_UNSIGNED = 0;
  localparam int SGN_TWOS = 1;
  function automatic int clog2c(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dot_product_stream_adder_tree.sv
// dp_adder_tree: registered binary adder tree with enable and valid/last sideband
//  ports: clk, reset (sync, active-high), en (advance when 1), in_valid/in_last/in_data (N lanes of IW bits),
//         out_valid/out_last/out_data (IW+ceil(log2 N) bits, ceil(log2 N) cycles later; combinational for N=1)
module dp_adder_tree
  import dot_product_stream_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = 16,
  parameter int SIGNED = 0,
  localparam int L = clog2c(N),
  localparam int OW = IW + L
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [N*IW-1:0] in_data,
  output logic          out_valid,
  output logic          out_last,
  output logic [OW-1:0] out_data
);
  localparam int D = (L == 0) ? 1 : L;
  // nd[l] is the input row of level l; rows are 2N wide so pairs never index past the end,
  // and unused nodes stay zero, which pads odd leaves
  logic [OW-1:0] nd [D][2*N];
  logic [OW-1:0] lv_d [D][2*N];
  logic [OW-1:0] lv_q [D][2*N];
  logic [D-1:0] vld_d, vld_q, lst_d, lst_q;
  always_comb begin
    for (int k = 0; k < 2*N; k++) nd[0][k] = '0;
    for (int k = 0; k < N; k++)
      if (SIGNED == SGN_TWOS) nd[0][k] = OW'($signed(in_data[k*IW +: IW]));
      else nd[0][k] = OW'(in_data[k*IW +: IW]);
    for (int l = 1; l < D; l++) nd[l] = lv_q[l-1];
    for (int l = 0; l < D; l++) begin
      for (int k = 0; k < 2*N; k++) lv_d[l][k] = '0;
      for (int k = 0; k < N; k++) lv_d[l][k] = nd[l][2*k] + nd[l][2*k+1];
    end
    vld_d = D'({vld_q, in_valid});
    lst_d = D'({lst_q, in_last});
  end
  always_ff @(posedge clk)
    if (reset) begin
      lv_q <= '{default: '0};
      vld_q <= '0;
      lst_q <= '0;
    end else if (en) begin
      lv_q <= lv_d;
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  assign out_valid = (L == 0) ? in_valid : vld_q[D-1];
  assign out_last = (L == 0) ? in_last : lst_q[D-1];
  assign out_data = (L == 0) ? nd[0][0] : lv_q[D-1][0];
endmodule

// File: rtl/dot_product_stream.sv
// dot_product_stream: pipelined N-lane dot-product engine accumulating segments until in_last
//  ports: clk, reset (sync, active-high); in_valid/in_ready/in_last/a/b (lane i at [i*DW +: DW]);
//         out_valid/out_ready/result/overflow. Optional macro DOT_PRODUCT_SAT_EN: saturating
//         accumulation with sticky per-vector overflow; otherwise modulo-2^ACCW wrap, overflow tied 0.
module dot_product_stream
  import dot_product_stream_pkg::*;
#(
  parameter int N = 3,
  parameter int DW = 8,
  parameter int ACCW = 18,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [N*DW-1:0] a,
  input  logic [N*DW-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] result,
  output logic            overflow
);
  localparam int PW = 2 * DW;
  localparam int SW = PW + clog2c(N);
  if (ACCW < SW) begin : g_bad_accw
    $error("dot_product_stream: ACCW must be at least 2*DW+clog2(N)");
  end
  logic stall;
  logic [N*PW-1:0] mul, prod_d, prod_q;
  logic mv_d, mv_q, ml_d, ml_q;
  logic tv, tl;
  logic [SW-1:0] ts;
  logic [ACCW-1:0] sx, base, acc_n, acc_d, acc_q, res_d, res_q;
  logic first_d, first_q, ovld_d, ovld_q;
`ifdef DOT_PRODUCT_SAT_EN
  logic [ACCW:0] s_w;
  logic ovf, ova_n, ova_d, ova_q, ov_d, ov_q;
  assign overflow = ov_q;
`else
  assign overflow = 1'b0;
`endif
  assign stall = ovld_q & ~out_ready;
  assign in_ready = ~stall;
  assign out_valid = ovld_q;
  assign result = res_q;
  dp_adder_tree #(.N(N), .IW(PW), .SIGNED(SIGNED)) u_tree (
    .clk(clk),
    .reset(reset),
    .en(~stall),
    .in_valid(mv_q),
    .in_last(ml_q),
    .in_data(prod_q),
    .out_valid(tv),
    .out_last(tl),
    .out_data(ts)
  );
  always_comb begin
    mul = '0;
    for (int i = 0; i < N; i++)
      if (SIGNED == SGN_TWOS) mul[i*PW +: PW] = PW'($signed(a[i*DW +: DW])) * PW'($signed(b[i*DW +: DW]));
      else mul[i*PW +: PW] = PW'(a[i*DW +: DW]) * PW'(b[i*DW +: DW]);
    prod_d = stall ? prod_q : mul;
    mv_d = stall ? mv_q : in_valid;
    ml_d = stall ? ml_q : in_last;
    if (SIGNED == SGN_TWOS) sx = ACCW'($signed(ts));
    else sx = ACCW'(ts);
    base = first_q ? '0 : acc_q;
`ifdef DOT_PRODUCT_SAT_EN
    // one guard bit exposes the overflow; clamp toward the side it overflowed
    s_w = {(SIGNED == SGN_TWOS) & sx[ACCW-1], sx} + {(SIGNED == SGN_TWOS) & base[ACCW-1], base};
    ovf = (SIGNED == SGN_TWOS) ? s_w[ACCW] ^ s_w[ACCW-1] : s_w[ACCW];
    acc_n = !ovf ? s_w[ACCW-1:0] : (SIGNED == SGN_TWOS) ? {s_w[ACCW], {(ACCW-1){~s_w[ACCW]}}} : '1;
    ova_n = (!first_q & ova_q) | ovf;
    ova_d = ova_q;
    ov_d = ov_q;
`else
    acc_n = base + sx;
`endif
    acc_d = acc_q;
    first_d = first_q;
    res_d = res_q;
    ovld_d = ovld_q;
    if (!stall) begin
      ovld_d = tv & tl;
      if (tv & tl) begin
        res_d = acc_n;
        acc_d = '0;
        first_d = 1'b1;
`ifdef DOT_PRODUCT_SAT_EN
        ov_d = ova_n;
`endif
      end else if (tv) begin
        acc_d = acc_n;
        first_d = 1'b0;
`ifdef DOT_PRODUCT_SAT_EN
        ova_d = ova_n;
`endif
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      prod_q <= '0;
      mv_q <= 1'b0;
      ml_q <= 1'b0;
      acc_q <= '0;
      first_q <= 1'b1;
      res_q <= '0;
      ovld_q <= 1'b0;
`ifdef DOT_PRODUCT_SAT_EN
      ova_q <= 1'b0;
      ov_q <= 1'b0;
`endif
    end else begin
      prod_q <= prod_d;
      mv_q <= mv_d;
      ml_q <= ml_d;
      acc_q <= acc_d;
      first_q <= first_d;
      res_q <= res_d;
      ovld_q <= ovld_d;
`ifdef DOT_PRODUCT_SAT_EN
      ova_q <= ova_d;
      ov_q <= ov_d;
`endif
    end
endmodule

// File: tb/tb_dot_product_stream.sv
// tb_dot_product_stream: randomized and directed checks of unsigned and signed instances against a queue model
module tb_dot_product_stream;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [23:0] a = '0, b = '0;
  logic u_rdy, u_vld, u_ovf, s_rdy, s_vld, s_ovf;
  logic [17:0] u_res, s_res;
  int total = 0, bad = 0, mode = 0;
  typedef struct packed {logic [17:0] r; logic o;} exp_t;
  exp_t qu[$], qs[$];
  longint accu = 0, accs = 0;
  bit fu = 0, fs = 0, rst_prev = 0, stall_prev = 0;
  logic [17:0] res_prev = '0;
`ifdef DOT_PRODUCT_SAT_EN
  localparam longint MAXU = 262143, MAXS = 131071, MINS = -131072;
  localparam logic [17:0] E255 = 18'd262143;
  localparam logic O255 = 1'b1;
`else
  localparam logic [17:0] E255 = 18'd128006;
  localparam logic O255 = 1'b0;
`endif
  always #5 clk = ~clk;
  dot_product_stream #(.N(3), .DW(8), .ACCW(18), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_rdy), .in_last(in_last),
    .a(a), .b(b), .out_valid(u_vld), .out_ready(out_ready), .result(u_res), .overflow(u_ovf)
  );
  dot_product_stream #(.N(3), .DW(8), .ACCW(18), .SIGNED(1)) s_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_rdy), .in_last(in_last),
    .a(a), .b(b), .out_valid(s_vld), .out_ready(out_ready), .result(s_res), .overflow(s_ovf)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [23:0] pk(input logic [7:0] x0, x1, x2);
    return {x2, x1, x0};
  endfunction
  function automatic longint bsum(input logic [23:0] x, y, input bit sg);
    longint s = 0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] p, q;
      p = x[i*8 +: 8];
      q = y[i*8 +: 8];
      if (sg) s += longint'($signed(p)) * longint'($signed(q));
      else s += longint'(p) * longint'(q);
    end
    return s;
  endfunction
  task automatic model_beat();
    longint bu, bs;
    bu = bsum(a, b, 0);
    bs = bsum(a, b, 1);
    accu += bu;
    accs += bs;
`ifdef DOT_PRODUCT_SAT_EN
    if (accu > MAXU) begin accu = MAXU; fu = 1; end
    if (accs > MAXS) begin accs = MAXS; fs = 1; end
    if (accs < MINS) begin accs = MINS; fs = 1; end
`endif
    if (in_last) begin
      qu.push_back('{r: 18'(accu), o: fu});
      qs.push_back('{r: 18'(accs), o: fs});
      accu = 0; accs = 0; fu = 0; fs = 0;
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      if (rst_prev) begin
        chk("rst_vld_u", 64'(u_vld), 64'(0));
        chk("rst_res_u", 64'(u_res), 64'(0));
        chk("rst_ovf_u", 64'(u_ovf), 64'(0));
        chk("rst_vld_s", 64'(s_vld), 64'(0));
      end
      accu = 0; accs = 0; fu = 0; fs = 0;
      qu.delete();
      qs.delete();
      stall_prev = 0;
    end else begin
      chk("in_ready_u", 64'(u_rdy), 64'(!(u_vld && !out_ready)));
      chk("in_ready_s", 64'(s_rdy), 64'(!(s_vld && !out_ready)));
      if (stall_prev) begin
        chk("hold_vld", 64'(u_vld), 64'(1));
        chk("hold_res", 64'(u_res), 64'(res_prev));
      end
      if (u_vld) begin
        if (qu.size() == 0) chk("spurious_u", 64'(u_vld), 64'(0));
        else begin
          chk("res_u", 64'(u_res), 64'(qu[0].r));
          chk("ovf_u", 64'(u_ovf), 64'(qu[0].o));
          if (out_ready) void'(qu.pop_front());
        end
      end
      if (s_vld) begin
        if (qs.size() == 0) chk("spurious_s", 64'(s_vld), 64'(0));
        else begin
          chk("res_s", 64'(s_res), 64'(qs[0].r));
          chk("ovf_s", 64'(s_ovf), 64'(qs[0].o));
          if (out_ready) void'(qs.pop_front());
        end
      end
      if (in_valid && u_rdy) model_beat();
      stall_prev = u_vld && !out_ready;
      res_prev = u_res;
    end
    rst_prev = reset;
  end
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode != 2);
    end
  end
  task automatic beat(input logic [23:0] x, y, input logic l);
    int n = 0;
    bit ok;
    in_valid = 1'b1; a = x; b = y; in_last = l;
    forever begin
      @(negedge clk);
      ok = u_rdy;
      @(posedge clk);
      #1;
      if (ok) break;
      if (++n > 100) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: in_ready low for %0d cycles, expected high", n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic lat_test(input logic [23:0] x, y, input logic [17:0] eu, es, input logic eo, input string nm);
    int n = 0;
    beat(x, y, 1'b1);
    do begin
      @(negedge clk);
      n++;
    end while (!u_vld && n < 20);
    chk({nm, "_lat"}, 64'(n), 64'(4));
    chk({nm, "_u"}, 64'(u_res), 64'(eu));
    chk({nm, "_s"}, 64'(s_res), 64'(es));
    chk({nm, "_ovf"}, 64'(u_ovf), 64'(eo));
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(u_rdy), 64'(1));
    chk("rst_out_valid", 64'(u_vld), 64'(0));
    @(posedge clk);
    #1;
    lat_test(pk(1, 2, 3), pk(4, 5, 6), 18'd32, 18'd32, 1'b0, "basic");
    beat(pk(1, 1, 1), pk(1, 1, 1), 1'b0);
    lat_test(pk(2, 2, 2), pk(3, 3, 3), 18'd21, 18'd21, 1'b0, "two_seg");
    lat_test(pk(8'hFF, 8'd2, 8'hFD), pk(8'd4, 8'hFB, 8'd6), 18'd3040, 18'h3FFE0, 1'b0, "signed");
    beat(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    lat_test(24'hFFFFFF, 24'hFFFFFF, E255, 18'd6, O255, "max");
    beat(pk(9, 9, 9), pk(9, 9, 9), 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_res", 64'(u_res), 64'(0));
    lat_test(pk(1, 2, 3), pk(4, 5, 6), 18'd32, 18'd32, 1'b0, "after_rst");
    fork
      begin
        for (int i = 0; i < 8; i++) beat(pk(8'(i), 8'(i + 1), 8'(i + 2)), pk(3, 2, 1), 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 mode = 2;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 64'(u_rdy), 64'(0));
        chk("stall_valid", 64'(u_vld), 64'(1));
        mode = 0;
      end
    join
    mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        logic [23:0] x, y;
        x = 24'($urandom);
        y = 24'($urandom);
        if ($urandom_range(0, 7) == 0) begin x = '1; y = '1; end
        beat(x, y, $urandom_range(0, 2) == 0);
      end
    end
    beat(pk(5, 6, 7), pk(7, 6, 5), 1'b1);
    mode = 0;
    for (int n = 0; n < 100 && (qu.size() != 0 || qs.size() != 0 || u_vld); n++) @(posedge clk);
    @(negedge clk);
    chk("drain_u", 64'(qu.size()), 64'(0));
    chk("drain_s", 64'(qs.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
